sha3_msg_padder: RTL and testbench

Front-end initiator for sha3_core (SHA3-256, 1088-bit rate). It accepts a byte stream over valid/ready and packs bytes MSB-first into rate blocks. It applies SHA-3 domain padding (0x06 … 0x80) and drives the core's message_block/start/is_last/ready handshake one block at a time. It then returns the 256-bit digest over a valid/ready output.

---
 rtl/sha3_msg_padder_pkg.sv | 28 ++
 rtl/sha3_msg_padder_if.sv | 23 ++
 rtl/sha3_msg_padder_block_packer.sv | 58 +++++
 rtl/sha3_msg_padder.sv | 155 +++++++++++++++
 tb/tb_sha3_msg_padder.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha3_msg_padder_pkg.sv
// Shared constants, state encoding and helpers for the SHA3-256 message padder.
package sha3_msg_padder_pkg;

  localparam int RATE_BYTES = 136;
  localparam int RATE_W     = 8 * RATE_BYTES;
  localparam int DIGEST_W   = 256;
  localparam int CNT_W      = 8;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  // Block that carries only padding: empty message, or overflow after a full last block.
  localparam logic [RATE_W-1:0] PAD_BLOCK = {PAD_DOMAIN, {(RATE_W-16){1'b0}}, PAD_FINAL};

  typedef enum logic [2:0] {
    ST_FILL,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_OUT
  } state_e;

  // Bit index of the MSB of byte k; byte 0 sits at the top of the block.
  function automatic int byte_msb(input int k);
    return RATE_W - 1 - 8 * k;
  endfunction

endpackage

// File: rtl/sha3_msg_padder_if.sv
// Byte-stream input and digest output handshakes of the padder.
interface sha3_msg_padder_if;

  logic [7:0]                                 in_data;
  logic                                       in_valid;
  logic                                       in_last;
  logic                                       in_empty;
  logic                                       in_ready;
  logic [sha3_msg_padder_pkg::DIGEST_W-1:0]   digest;
  logic                                       digest_valid;
  logic                                       digest_ready;

  modport slave (
    input  in_data, in_valid, in_last, in_empty, digest_ready,
    output in_ready, digest, digest_valid
  );

  modport master (
    output in_data, in_valid, in_last, in_empty, digest_ready,
    input  in_ready, digest, digest_valid
  );

endinterface

// File: rtl/sha3_msg_padder_block_packer.sv
// Rate-block byte buffer: MSB-first byte writes, in-place SHA-3 padding, clear and pad-only load.
module sha3_block_packer
  import sha3_msg_padder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              pad_en,
  input  logic              clr,
  input  logic              load_pad,
  output logic [RATE_W-1:0] block,
  output logic [CNT_W-1:0]  byte_cnt
);

  logic [RATE_W-1:0] block_d, block_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  // Next buffer: clear/load win; otherwise optional byte write, then padding placed after it.
  always_comb begin
    block_d = block_q;
    cnt_d   = cnt_q;
    if (clr) begin
      block_d = '0;
      cnt_d   = '0;
    end else if (load_pad) begin
      block_d = PAD_BLOCK;
      cnt_d   = '0;
    end else begin
      if (wr_en && (cnt_q < CNT_W'(RATE_BYTES))) begin
        block_d[byte_msb(int'(cnt_q)) -: 8] = wr_data;
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Both XORs landing on byte 135 yields 0x86 when only one byte remains.
      if (pad_en && (cnt_d < CNT_W'(RATE_BYTES))) begin
        block_d[byte_msb(int'(cnt_d)) -: 8] =
          block_d[byte_msb(int'(cnt_d)) -: 8] ^ PAD_DOMAIN;
        block_d[byte_msb(RATE_BYTES-1) -: 8] =
          block_d[byte_msb(RATE_BYTES-1) -: 8] ^ PAD_FINAL;
      end
    end
  end

  // Buffer and byte counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= '0;
      cnt_q   <= '0;
    end else begin
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

  assign block    = block_q;
  assign byte_cnt = cnt_q;

endmodule

// File: rtl/sha3_msg_padder.sv
// SHA3-256 front end: packs a byte stream into padded rate blocks, drives the core, returns the digest.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_FILL      | accepting bytes into the block buffer
// ST_ISSUE     | block ready; pulse core_start once core_ready is high
// ST_WAIT_BUSY | waiting for the core to drop ready after start
// ST_WAIT_DONE | core permuting; next block, digest capture or refill on ready
// ST_OUT       | digest held until the consumer takes it
module sha3_msg_padder
  import sha3_msg_padder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  sha3_msg_padder_if.slave    bus,
  output logic [RATE_W-1:0]   core_block,
  output logic                core_start,
  output logic                core_is_last,
  input  logic                core_ready,
  input  logic [DIGEST_W-1:0] core_hash
);

  state_e                state_d, state_q;
  logic                  pad_pending_d, pad_pending_q;
  logic                  is_last_d, is_last_q;
  logic                  live_d, live_q;
  logic [DIGEST_W-1:0]   digest_d, digest_q;

  logic                  wr_en, pad_en, clr, load_pad;
  logic                  in_ready;
  logic                  accept;
  logic                  fills_block;
  logic [CNT_W-1:0]      byte_cnt;

  sha3_block_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (bus.in_data),
    .pad_en   (pad_en),
    .clr      (clr),
    .load_pad (load_pad),
    .block    (core_block),
    .byte_cnt (byte_cnt)
  );

  // live_q keeps in_ready low until the first clock after reset release.
  assign live_d      = 1'b1;
  assign in_ready    = (state_q == ST_FILL) && live_q;
  assign accept      = bus.in_valid && in_ready;
  assign fills_block = (byte_cnt == CNT_W'(RATE_BYTES - 1));

  // Next-state, packer controls and core start pulse.
  always_comb begin
    state_d       = state_q;
    pad_pending_d = pad_pending_q;
    is_last_d     = is_last_q;
    digest_d      = digest_q;
    wr_en         = 1'b0;
    pad_en        = 1'b0;
    clr           = 1'b0;
    load_pad      = 1'b0;
    core_start    = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (bus.in_last) begin
            if (bus.in_empty) begin
              pad_en    = 1'b1;
              is_last_d = 1'b1;
            end else if (fills_block) begin
              // Last byte fills the block: padding moves to a separate block.
              wr_en         = 1'b1;
              pad_pending_d = 1'b1;
              is_last_d     = 1'b0;
            end else begin
              wr_en     = 1'b1;
              pad_en    = 1'b1;
              is_last_d = 1'b1;
            end
            state_d = ST_ISSUE;
          end else if (!bus.in_empty) begin
            wr_en = 1'b1;
            if (fills_block) begin
              is_last_d = 1'b0;
              state_d   = ST_ISSUE;
            end
          end
        end
      end

      ST_ISSUE: begin
        if (core_ready) begin
          core_start = 1'b1;
          state_d    = ST_WAIT_BUSY;
        end
      end

      ST_WAIT_BUSY: begin
        if (!core_ready) state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (core_ready) begin
          if (pad_pending_q) begin
            load_pad      = 1'b1;
            pad_pending_d = 1'b0;
            is_last_d     = 1'b1;
            state_d       = ST_ISSUE;
          end else if (is_last_q) begin
            digest_d = core_hash;
            state_d  = ST_OUT;
          end else begin
            clr     = 1'b1;
            state_d = ST_FILL;
          end
        end
      end

      ST_OUT: begin
        if (bus.digest_ready) begin
          clr       = 1'b1;
          is_last_d = 1'b0;
          state_d   = ST_FILL;
        end
      end

      default: state_d = ST_FILL;
    endcase
  end

  // Control and digest registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      pad_pending_q <= 1'b0;
      is_last_q     <= 1'b0;
      live_q        <= 1'b0;
      digest_q      <= '0;
    end else begin
      state_q       <= state_d;
      pad_pending_q <= pad_pending_d;
      is_last_q     <= is_last_d;
      live_q        <= live_d;
      digest_q      <= digest_d;
    end
  end

  assign core_is_last     = is_last_q;
  assign bus.in_ready     = in_ready;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = (state_q == ST_OUT);

endmodule

// File: tb/tb_sha3_msg_padder.sv
// Directed bench for sha3_msg_padder with a behavioural sha3_core handshake model.
module tb_sha3_msg_padder;
  import sha3_msg_padder_pkg::*;

  localparam logic [DIGEST_W-1:0] H_EMPTY = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
  localparam logic [DIGEST_W-1:0] H_ABC   = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
  localparam logic [DIGEST_W-1:0] H_FOX   = 256'h69070dda01975c8c120c3aada1b282394e7f032fa9cf32f4cb2259a0897dfc04;
  localparam logic [DIGEST_W-1:0] H_A135  = 256'h1111222233334444555566667777888899990000aaaabbbbccccddddeeeeffff;
  localparam logic [DIGEST_W-1:0] H_A136  = 256'hfedcba9876543210fedcba9876543210a5a5a5a55a5a5a5a0123456789abcdef;
  localparam logic [RATE_W-1:0]   BLK_PAD = {8'h06, 1072'h0, 8'h80};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_msg_padder_if bus();

  logic [RATE_W-1:0]   core_block;
  logic                core_start;
  logic                core_is_last;
  logic                core_ready;
  logic [DIGEST_W-1:0] core_hash;

  sha3_msg_padder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .core_block   (core_block),
    .core_start   (core_start),
    .core_is_last (core_is_last),
    .core_ready   (core_ready),
    .core_hash    (core_hash)
  );

  int total = 0;
  int bad   = 0;

  // Core model: captures each started block, drops ready next cycle, busy for a few cycles.
  logic [RATE_W-1:0] cap_block [32];
  logic              cap_last  [32];
  int                n_starts = 0;
  int                busy_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready <= 1'b1;
      busy_cnt   <= 0;
    end else if (core_start && core_ready) begin
      cap_block[n_starts % 32] <= core_block;
      cap_last[n_starts % 32]  <= core_is_last;
      n_starts   <= n_starts + 1;
      core_ready <= 1'b0;
      busy_cnt   <= 5;
    end else if (!core_ready) begin
      if (busy_cnt <= 1) core_ready <= 1'b1;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
    int t;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_empty = e;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_beat_timeout in_ready=%0b after %0d cycles", bus.in_ready, t);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  task automatic check_block(input int idx, input logic [RATE_W-1:0] exp,
                             input logic exp_last, input string name);
    logic [RATE_W-1:0] got;
    int first;
    got = cap_block[idx % 32];
    total++;
    if (got !== exp) begin
      bad++;
      first = -1;
      for (int k = RATE_BYTES - 1; k >= 0; k--)
        if (got[byte_msb(k) -: 8] !== exp[byte_msb(k) -: 8]) first = k;
      $display("FAIL %s_block first bad byte %0d got=%h exp=%h", name, first,
               got[byte_msb(first < 0 ? 0 : first) -: 8], exp[byte_msb(first < 0 ? 0 : first) -: 8]);
    end
    total++;
    if (cap_last[idx % 32] !== exp_last) begin
      bad++;
      $display("FAIL %s_is_last got=%0b exp=%0b", name, cap_last[idx % 32], exp_last);
    end
  endtask

  task automatic check_starts(input int base, input int n, input string name);
    total++;
    if (n_starts - base !== n) begin
      bad++;
      $display("FAIL %s_starts got=%0d exp=%0d", name, n_starts - base, n);
    end
  endtask

  task automatic wait_digest(input logic [DIGEST_W-1:0] exp, input string name);
    int t = 0;
    while (!bus.digest_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (!bus.digest_valid) begin
      bad++;
      $display("FAIL %s_digest_timeout digest_valid=%0b", name, bus.digest_valid);
    end else if (bus.digest !== exp) begin
      bad++;
      $display("FAIL %s_digest got=%h exp=%h", name, bus.digest, exp);
    end
  endtask

  task automatic take_digest(input string name);
    bus.digest_ready = 1'b1;
    @(negedge clk);
    bus.digest_ready = 1'b0;
    total++;
    if (bus.digest_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_handshake digest_valid=%0b in_ready=%0b exp 0/1", name,
               bus.digest_valid, bus.in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (bus.in_ready !== 1'b0 || core_start !== 1'b0 || core_is_last !== 1'b0 ||
        bus.digest_valid !== 1'b0 || bus.digest !== '0 || core_block !== '0) begin
      bad++;
      $display("FAIL %s_outputs in_ready=%0b start=%0b is_last=%0b dv=%0b digest_zero=%0b block_zero=%0b exp 0 0 0 0 1 1",
               name, bus.in_ready, core_start, core_is_last, bus.digest_valid,
               bus.digest == '0, core_block == '0);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_in_ready got=%0b exp=0", bus.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_cycle_in_ready got=%0b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_empty();
    int s = n_starts;
    core_hash = H_EMPTY;
    send_beat(8'h00, 1'b1, 1'b1);
    wait_digest(H_EMPTY, "empty");
    check_starts(s, 1, "empty");
    check_block(s, BLK_PAD, 1'b1, "empty");
    take_digest("empty");
  endtask

  task automatic test_abc();
    int s = n_starts;
    int t = 0;
    bit ready_ok = 1'b1;
    core_hash = H_ABC;
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h5a, 1'b0, 1'b1);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    total++;
    if (core_start !== 1'b1) begin
      bad++;
      $display("FAIL abc_start_latency core_start=%0b exp=1", core_start);
    end
    @(negedge clk);
    while (!core_ready && t < 50) begin
      if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
      @(negedge clk);
      t++;
    end
    total++;
    if (bus.digest_valid !== 1'b0 || !ready_ok) begin
      bad++;
      $display("FAIL abc_busy digest_valid=%0b in_ready_low=%0b exp 0/1", bus.digest_valid, ready_ok);
    end
    @(negedge clk);
    total++;
    if (bus.digest_valid !== 1'b1) begin
      bad++;
      $display("FAIL abc_digest_latency digest_valid=%0b exp=1", bus.digest_valid);
    end
    wait_digest(H_ABC, "abc");
    check_starts(s, 1, "abc");
    check_block(s, {24'h616263, 8'h06, 1048'h0, 8'h80}, 1'b1, "abc");
    take_digest("abc");
  endtask

  task automatic test_135();
    int s = n_starts;
    core_hash = H_A135;
    for (int i = 0; i < 135; i++) send_beat(8'h61, i == 134, 1'b0);
    wait_digest(H_A135, "a135");
    check_starts(s, 1, "a135");
    check_block(s, {{135{8'h61}}, 8'h86}, 1'b1, "a135");
    take_digest("a135");
  endtask

  task automatic test_136();
    int s = n_starts;
    int t = 0;
    bit ready_ok = 1'b1;
    core_hash = H_A136;
    for (int i = 0; i < 136; i++) send_beat(8'h61, i == 135, 1'b0);
    while (n_starts < s + 2 && t < 100) begin
      if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
      @(negedge clk);
      t++;
    end
    total++;
    if (!ready_ok) begin
      bad++;
      $display("FAIL a136_in_ready_between got=1 exp=0");
    end
    wait_digest(H_A136, "a136");
    check_starts(s, 2, "a136");
    check_block(s, {136{8'h61}}, 1'b0, "a136_first");
    check_block(s + 1, BLK_PAD, 1'b1, "a136_second");
    take_digest("a136");
  endtask

  task automatic test_back_to_back();
    logic [343:0] fox;
    int s = n_starts;
    bit hold_ok = 1'b1;
    fox = "The quick brown fox jumps over the lazy dog";
    core_hash = H_FOX;
    for (int i = 0; i < 43; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(fox[343-8*i -: 8], i == 42, 1'b0);
    end
    wait_digest(H_FOX, "fox");
    // Offer the next (empty) message while the digest is held.
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_empty = 1'b1;
    core_hash    = H_EMPTY;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.digest_valid !== 1'b1 || bus.digest !== H_FOX || bus.in_ready !== 1'b0)
        hold_ok = 1'b0;
    end
    total++;
    if (!hold_ok || n_starts != s + 1) begin
      bad++;
      $display("FAIL fox_hold stable=%0b starts=%0d exp stable=1 starts=1", hold_ok, n_starts - s);
    end
    check_block(s, {fox, 8'h06, 728'h0, 8'h80}, 1'b1, "fox");
    take_digest("fox");
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    wait_digest(H_EMPTY, "fox_next");
    check_starts(s, 2, "fox_next");
    check_block(s + 1, BLK_PAD, 1'b1, "fox_next");
    take_digest("fox_next");
  endtask

  task automatic test_mid_reset();
    int s = n_starts;
    int t = 0;
    core_hash = H_A136;
    for (int i = 0; i < 136; i++) send_beat(8'(i), 1'b0, 1'b0);
    while (n_starts < s + 1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_starts(s, 1, "midrst");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst_async");
    @(negedge clk);
    check_reset_outputs("midrst_held");
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.digest_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_restart in_ready=%0b digest_valid=%0b exp 1/0", bus.in_ready, bus.digest_valid);
    end
    test_abc();
  endtask

  initial begin
    bus.in_data      = 8'h00;
    bus.in_valid     = 1'b0;
    bus.in_last      = 1'b0;
    bus.in_empty     = 1'b0;
    bus.digest_ready = 1'b0;
    core_hash        = '0;
    test_reset();
    test_empty();
    test_abc();
    test_135();
    test_136();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
